// File: rtl/pipelined_binary_tree_adder.sv
// Pipelined binary-tree reducer: sums INPUTS_AMOUNT P-bit operands through log2 adder layers,
// with a valid/ready register stage after every PIPE_STRIDE layers. Signedness rides with each beat.
module pipelined_binary_tree_adder #(
  parameter int INPUTS_AMOUNT = 8,
  parameter int P             = 8,
  parameter int PIPE_STRIDE   = 1,
  parameter int OUT_W         = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [P-1:0]     inputs_i [INPUTS_AMOUNT],
  input  logic             signed_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [OUT_W-1:0] out_o,
  output logic             out_signed_o
);
  localparam int N   = INPUTS_AMOUNT;
  localparam int L   = $clog2(N);
  localparam int FW  = P + L;
  localparam int STR = (PIPE_STRIDE == 0) ? 1 : PIPE_STRIDE;
  localparam int S   = (PIPE_STRIDE == 0 || L == 0) ? 0 : (L + STR - 1) / STR;
  localparam int SV  = (S == 0) ? 1 : S;

  if (N < 1 || (N & (N - 1)) != 0) begin : gen_bad_n
    $fatal(1, "INPUTS_AMOUNT must be a power of 2 and >= 1");
  end

  // Operands are widened to the full result width once; the tree cannot overflow FW bits,
  // so adding pre-extended values gives the same result as extending one bit per layer.
  function automatic logic [FW-1:0] ext_op(input logic [P-1:0] x, input logic s);
    return s ? FW'(signed'(x)) : FW'(x);
  endfunction

  function automatic logic [OUT_W-1:0] fit_out(input logic [FW-1:0] x, input logic s);
    return s ? OUT_W'(signed'(x)) : OUT_W'(x);
  endfunction

  logic [FW-1:0] lay [L+1][N];
  logic          sg  [L+1];
  logic [SV-1:0] v_q;
  logic [SV:0]   rdy;
  logic [SV-1:0] up_vld;
  logic [SV-1:0] ld_en;

  for (genvar i = 0; i < N; i++) begin : gen_ext
    assign lay[0][i] = ext_op(inputs_i[i], signed_i);
  end
  assign sg[0] = signed_i;

  for (genvar k = 0; k < L; k++) begin : gen_layer
    localparam int PAIRS = N >> (k + 1);
    localparam bit REG   = (S > 0) && (((k + 1) % STR == 0) || (k == L - 1));
    localparam int STG   = k / STR;

    for (genvar j = 0; j < N; j++) begin : gen_pair
      if (j < PAIRS) begin : gen_add
        logic [FW-1:0] sum_d;
        assign sum_d = lay[k][2*j] + lay[k][2*j+1];
        if (REG) begin : gen_q
          logic [FW-1:0] sum_q;
          // Stage boundary: data captured only when a valid beat loads
          always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni)          sum_q <= '0;
            else if (ld_en[STG])  sum_q <= sum_d;
          end
          assign lay[k+1][j] = sum_q;
        end else begin : gen_comb
          assign lay[k+1][j] = sum_d;
        end
      end else begin : gen_unused
        assign lay[k+1][j] = '0;
      end
    end

    if (REG) begin : gen_sg_q
      logic sg_q;
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)          sg_q <= 1'b0;
        else if (ld_en[STG])  sg_q <= sg[k];
      end
      assign sg[k+1] = sg_q;
    end else begin : gen_sg_c
      assign sg[k+1] = sg[k];
    end
  end

  if (S > 0) begin : gen_ctrl
    // A stage may load whenever it is empty or its content moves on this cycle,
    // which lets bubbles collapse under downstream stall.
    always_comb begin
      rdy    = '0;
      rdy[S] = out_ready_i;
      for (int s = S - 1; s >= 0; s--) rdy[s] = ~v_q[s] | rdy[s+1];
    end

    always_comb begin
      up_vld    = '0;
      up_vld[0] = in_valid_i;
      for (int s = 1; s < S; s++) up_vld[s] = v_q[s-1];
    end

    assign ld_en = rdy[SV-1:0] & up_vld & {SV{~clear_i}};

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        v_q <= '0;
      end else if (clear_i) begin
        v_q <= '0;
      end else begin
        for (int s = 0; s < S; s++) begin
          if (rdy[s]) v_q[s] <= up_vld[s];
        end
      end
    end

    assign in_ready_o  = rdy[0] & ~clear_i;
    assign out_valid_o = v_q[S-1];
  end else begin : gen_no_ctrl
    assign v_q         = '0;
    assign rdy         = '0;
    assign up_vld      = '0;
    assign ld_en       = '0;
    assign in_ready_o  = out_ready_i;
    assign out_valid_o = in_valid_i;
  end

  assign out_o        = fit_out(lay[L][0], sg[L]);
  assign out_signed_o = sg[L];
endmodule

// File: tb/tb_pipelined_binary_tree_adder.sv
// Bench for pipelined_binary_tree_adder: several parameterisations checked against an
// integer-sum reference model with a scoreboard queue.
module tb_pipelined_binary_tree_adder;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        clr;
  logic [7:0]  din  [8];
  logic [7:0]  din1 [1];
  logic        sgn;
  logic        iv [5];
  logic        rd [5];
  logic        ir [5];
  logic        ov [5];
  logic        os [5];
  logic [31:0] outv [5];
  logic [9:0]  out2;

  int pass_cnt = 0;
  int total    = 0;
  logic [32:0] q[$];
  logic [32:0] exp_v;

  // u0: default (S=3); u1: stride 2 (S=2); u2: OUT_W=10; u3: combinational; u4: single input
  pipelined_binary_tree_adder #(.INPUTS_AMOUNT(8), .P(8), .PIPE_STRIDE(1), .OUT_W(32)) u0 (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clr), .in_valid_i(iv[0]), .in_ready_o(ir[0]),
    .inputs_i(din), .signed_i(sgn), .out_valid_o(ov[0]), .out_ready_i(rd[0]),
    .out_o(outv[0]), .out_signed_o(os[0]));
  pipelined_binary_tree_adder #(.INPUTS_AMOUNT(8), .P(8), .PIPE_STRIDE(2), .OUT_W(32)) u1 (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clr), .in_valid_i(iv[1]), .in_ready_o(ir[1]),
    .inputs_i(din), .signed_i(sgn), .out_valid_o(ov[1]), .out_ready_i(rd[1]),
    .out_o(outv[1]), .out_signed_o(os[1]));
  pipelined_binary_tree_adder #(.INPUTS_AMOUNT(8), .P(8), .PIPE_STRIDE(1), .OUT_W(10)) u2 (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clr), .in_valid_i(iv[2]), .in_ready_o(ir[2]),
    .inputs_i(din), .signed_i(sgn), .out_valid_o(ov[2]), .out_ready_i(rd[2]),
    .out_o(out2), .out_signed_o(os[2]));
  pipelined_binary_tree_adder #(.INPUTS_AMOUNT(8), .P(8), .PIPE_STRIDE(0), .OUT_W(32)) u3 (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clr), .in_valid_i(iv[3]), .in_ready_o(ir[3]),
    .inputs_i(din), .signed_i(sgn), .out_valid_o(ov[3]), .out_ready_i(rd[3]),
    .out_o(outv[3]), .out_signed_o(os[3]));
  pipelined_binary_tree_adder #(.INPUTS_AMOUNT(1), .P(8), .PIPE_STRIDE(1), .OUT_W(32)) u4 (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clr), .in_valid_i(iv[4]), .in_ready_o(ir[4]),
    .inputs_i(din1), .signed_i(sgn), .out_valid_o(ov[4]), .out_ready_i(rd[4]),
    .out_o(outv[4]), .out_signed_o(os[4]));

  // Reference: exact integer sum of the operands, reduced modulo 2^w.
  function automatic logic [31:0] model(input int n, input int w);
    longint acc = 0;
    for (int i = 0; i < n; i++)
      acc += sgn ? longint'($signed(din[i])) : longint'(din[i]);
    acc = acc & ((longint'(1) << w) - 1);
    return acc[31:0];
  endfunction

  task automatic fill(input logic [7:0] v, input logic s);
    for (int i = 0; i < 8; i++) din[i] = v;
    sgn = s;
  endtask

  task automatic rand_in();
    for (int i = 0; i < 8; i++) din[i] = 8'($urandom);
    sgn = 1'($urandom_range(0, 1));
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clr = 1'b0; fill(8'h00, 1'b0); din1[0] = 8'h00;
    for (int u = 0; u < 5; u++) begin iv[u] = 1'b0; rd[u] = 1'b1; end
    repeat (2) @(negedge clk);
    #1;
    total++; if (ov[0] !== 1'b0) $display("FAIL rst_ov0: got %b want 0", ov[0]); else pass_cnt++;
    total++; if (outv[0] !== 32'h0) $display("FAIL rst_out0: got %h want 0", outv[0]); else pass_cnt++;
    total++; if (os[0] !== 1'b0) $display("FAIL rst_os0: got %b want 0", os[0]); else pass_cnt++;
    total++; if (ir[0] !== 1'b1) $display("FAIL rst_ir0: got %b want 1", ir[0]); else pass_cnt++;
    total++; if (ov[1] !== 1'b0) $display("FAIL rst_ov1: got %b want 0", ov[1]); else pass_cnt++;
    total++; if (out2 !== 10'h0) $display("FAIL rst_out2: got %h want 0", out2); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_latency();
    for (int pass = 0; pass < 2; pass++) begin
      @(negedge clk);
      fill(8'hFF, (pass == 0)); iv[0] = 1'b1; rd[0] = 1'b1;
      #1;
      total++; if (ir[0] !== 1'b1) $display("FAIL lat_accept: got %b want 1", ir[0]); else pass_cnt++;
      for (int c = 1; c <= 3; c++) begin
        @(negedge clk);
        iv[0] = 1'b0;
        #1;
        total++;
        if (ov[0] !== (c == 3)) $display("FAIL lat_ov c%0d: got %b want %b", c, ov[0], (c == 3));
        else pass_cnt++;
      end
      total++;
      if (outv[0] !== ((pass == 0) ? 32'hFFFFFFF8 : 32'h000007F8))
        $display("FAIL lat_out s%0d: got %h want %h", 1 - pass, outv[0],
                 ((pass == 0) ? 32'hFFFFFFF8 : 32'h000007F8));
      else pass_cnt++;
      total++; if (os[0] !== (pass == 0)) $display("FAIL lat_os: got %b want %b", os[0], (pass == 0)); else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    int pops = 0;
    q.delete();
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      fill(8'hFF, c[0]); iv[0] = (c < 8); rd[0] = 1'b1;
      #1;
      if (c >= 3 && c < 11) begin
        total++; if (ov[0] !== 1'b1) $display("FAIL b2b_bubble c%0d: got %b want 1", c, ov[0]); else pass_cnt++;
      end
      if (ov[0] && rd[0]) begin
        pops++;
        exp_v = (q.size() > 0) ? q.pop_front() : 33'h1_DEADBEEF;
        total++;
        if ({os[0], outv[0]} !== exp_v) $display("FAIL b2b_data: got %h want %h", {os[0], outv[0]}, exp_v);
        else pass_cnt++;
      end
      if (iv[0] && ir[0]) q.push_back({sgn, model(8, 32)});
    end
    total++; if (pops !== 8) $display("FAIL b2b_count: got %0d want 8", pops); else pass_cnt++;
  endtask

  task automatic test_random();
    logic hold = 1'b0;
    logic [32:0] held = '0;
    int guard = 0;
    q.delete();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      rand_in();
      iv[0] = (c < 350) ? 1'($urandom_range(0, 1)) : 1'b0;
      rd[0] = (c < 350) ? ($urandom_range(0, 3) != 0) : 1'b1;
      #1;
      if (hold) begin
        total++;
        if ({os[0], outv[0]} !== held || ov[0] !== 1'b1)
          $display("FAIL rnd_stall_hold: got %b/%h want 1/%h", ov[0], {os[0], outv[0]}, held);
        else pass_cnt++;
      end
      hold = ov[0] && !rd[0];
      held = {os[0], outv[0]};
      if (ov[0] && rd[0]) begin
        exp_v = (q.size() > 0) ? q.pop_front() : 33'h1_DEADBEEF;
        total++;
        if ({os[0], outv[0]} !== exp_v) $display("FAIL rnd_data: got %h want %h", {os[0], outv[0]}, exp_v);
        else pass_cnt++;
      end
      if (iv[0] && ir[0]) q.push_back({sgn, model(8, 32)});
      guard = c;
    end
    total++; if (q.size() !== 0) $display("FAIL rnd_drain: got %0d left want 0 (after %0d)", q.size(), guard); else pass_cnt++;
  endtask

  task automatic test_stall();
    int acc = 0;
    q.delete();
    for (int i = 0; i < 8; i++) din[i] = 8'(i + 1);
    sgn = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      iv[1] = 1'b1; rd[1] = 1'b0;
      #1;
      if (c >= 2) begin
        total++;
        if (ov[1] !== 1'b1 || outv[1] !== 32'd36)
          $display("FAIL stall_hold c%0d: got %b/%0d want 1/36", c, ov[1], outv[1]);
        else pass_cnt++;
      end
      if (iv[1] && ir[1]) begin acc++; q.push_back({sgn, model(8, 32)}); end
    end
    total++; if (acc !== 2) $display("FAIL stall_buffered: got %0d want 2", acc); else pass_cnt++;
    total++; if (ir[1] !== 1'b0) $display("FAIL stall_ready: got %b want 0", ir[1]); else pass_cnt++;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      rand_in();
      iv[1] = (c < 6); rd[1] = 1'b1;
      #1;
      if (ov[1] && rd[1]) begin
        exp_v = (q.size() > 0) ? q.pop_front() : 33'h1_DEADBEEF;
        total++;
        if ({os[1], outv[1]} !== exp_v) $display("FAIL stall_order: got %h want %h", {os[1], outv[1]}, exp_v);
        else pass_cnt++;
      end
      if (iv[1] && ir[1]) q.push_back({sgn, model(8, 32)});
    end
    total++; if (q.size() !== 0) $display("FAIL stall_drain: got %0d left want 0", q.size()); else pass_cnt++;
  endtask

  task automatic test_out_trunc();
    int lat = -1;
    @(negedge clk);
    fill(8'hFF, 1'b0); iv[2] = 1'b1; rd[2] = 1'b1;
    for (int c = 1; c <= 10 && lat < 0; c++) begin
      @(negedge clk);
      iv[2] = 1'b0;
      #1;
      if (ov[2]) begin
        lat = c;
        total++; if (out2 !== 10'h3F8) $display("FAIL trunc_out: got %h want 3f8", out2); else pass_cnt++;
      end
    end
    total++; if (lat !== 3) $display("FAIL trunc_latency: got %0d want 3", lat); else pass_cnt++;
    q.delete();
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      rand_in(); iv[2] = (c < 6); rd[2] = 1'b1;
      #1;
      if (ov[2]) begin
        exp_v = (q.size() > 0) ? q.pop_front() : 33'h1_DEADBEEF;
        total++;
        if ({os[2], 22'h0, out2} !== exp_v) $display("FAIL trunc_rand: got %h want %h", {os[2], out2}, exp_v);
        else pass_cnt++;
      end
      if (iv[2] && ir[2]) q.push_back({sgn, model(8, 10)});
    end
  endtask

  task automatic test_async_reset();
    int seen = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      rand_in(); iv[0] = 1'b1; rd[0] = 1'b1;
    end
    @(negedge clk);
    iv[0] = 1'b0;
    #1;
    total++; if (ov[0] !== 1'b1) $display("FAIL arst_inflight: got %b want 1", ov[0]); else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (ov[0] !== 1'b0 || outv[0] !== 32'h0 || os[0] !== 1'b0)
      $display("FAIL arst_clear: got %b/%h/%b want 0/0/0", ov[0], outv[0], os[0]);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    q.delete();
    @(negedge clk);
    rand_in(); iv[0] = 1'b1;
    #1;
    if (ir[0]) q.push_back({sgn, model(8, 32)});
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      iv[0] = 1'b0;
      #1;
      if (ov[0]) begin
        seen++;
        exp_v = (q.size() > 0) ? q.pop_front() : 33'h1_DEADBEEF;
        total++;
        if ({os[0], outv[0]} !== exp_v) $display("FAIL arst_first: got %h want %h", {os[0], outv[0]}, exp_v);
        else pass_cnt++;
      end
    end
    total++; if (seen !== 1) $display("FAIL arst_count: got %0d want 1", seen); else pass_cnt++;
  endtask

  task automatic test_clear();
    int seen = 0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      rand_in(); iv[0] = 1'b1; rd[0] = 1'b1;
    end
    @(negedge clk);
    clr = 1'b1;
    #1;
    total++; if (ir[0] !== 1'b0) $display("FAIL clr_ready: got %b want 0", ir[0]); else pass_cnt++;
    @(negedge clk);
    clr = 1'b0; iv[0] = 1'b0;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (ov[0]) seen++;
      @(negedge clk);
    end
    total++; if (seen !== 0) $display("FAIL clr_flush: got %0d outputs want 0", seen); else pass_cnt++;
  endtask

  task automatic test_comb();
    @(negedge clk);
    din1[0] = 8'h80; sgn = 1'b1; iv[4] = 1'b1; rd[4] = 1'b1;
    #1;
    total++;
    if (ov[4] !== 1'b1 || outv[4] !== 32'hFFFFFF80 || os[4] !== 1'b1)
      $display("FAIL n1_out: got %b/%h/%b want 1/ffffff80/1", ov[4], outv[4], os[4]);
    else pass_cnt++;
    total++; if (ir[4] !== 1'b1) $display("FAIL n1_ready_hi: got %b want 1", ir[4]); else pass_cnt++;
    rd[4] = 1'b0; iv[4] = 1'b0;
    #1;
    total++; if (ir[4] !== 1'b0 || ov[4] !== 1'b0) $display("FAIL n1_follow: got %b/%b want 0/0", ir[4], ov[4]); else pass_cnt++;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      rand_in(); iv[3] = 1'($urandom_range(0, 1)); rd[3] = 1'($urandom_range(0, 1));
      #1;
      total++;
      if (outv[3] !== model(8, 32) || ov[3] !== iv[3] || ir[3] !== rd[3] || os[3] !== sgn)
        $display("FAIL comb_s0: got %h/%b/%b want %h/%b/%b", outv[3], ov[3], ir[3], model(8, 32), iv[3], rd[3]);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_back_to_back();
    test_random();
    test_stall();
    test_out_trunc();
    test_async_reset();
    test_clear();
    test_comb();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule

// File: doc/pipelined_binary_tree_adder.md
Name: pipelined_binary_tree_adder

Overview:
- Parametrised successor to the combinational binary tree adder.
- Reduces INPUTS_AMOUNT P-bit operands to one sum through log2(INPUTS_AMOUNT) adder layers, with registered pipeline stages inserted every PIPE_STRIDE layers.
- Each stage carries a valid/ready handshake, so the block sits between a streaming PE array and the output/writeback path and tolerates back-pressure.
- Signedness is selected per beat and travels with the data.

Parameters:
- INPUTS_AMOUNT, 8, number of operands; must be a power of 2 and >= 1. Elaboration $fatal otherwise.
- P, 8, width of each operand in bits.
- PIPE_STRIDE, 1, adder layers per pipeline stage; 0 = fully combinational (no registers).
- OUT_W, 32, output width; result is extended or truncated to this width.

Ports:
- clk_i, input, 1, clock.
- rst_ni, input, 1, asynchronous active-low reset.
- clear_i, input, 1, synchronous flush: drops all in-flight beats.
- in_valid_i, input, 1, operand vector valid.
- in_ready_o, output, 1, block can accept the operand vector this cycle.
- inputs_i, input, P x INPUTS_AMOUNT (unpacked array), operands, 2's complement when signed.
- signed_i, input, 1, 1 = signed addition, 0 = unsigned; sampled with the beat.
- out_valid_o, output, 1, sum valid.
- out_ready_i, input, 1, downstream accepts the sum.
- out_o, output, OUT_W, reduced sum.
- out_signed_o, output, 1, signedness of the beat currently on out_o.

Behaviour:
- Definitions:
  - L = $clog2(INPUTS_AMOUNT); full result width FW = P+L.
  - Number of stages S = 0 if PIPE_STRIDE==0 or L==0, else ceil(L/PIPE_STRIDE).
  - A stage register follows layer k when (k+1)%PIPE_STRIDE==0 or k==L-1.
- Arithmetic, per layer k:
  - Operands are P+k bits wide; each is extended by 1 bit (sign-extend if the beat's signed flag is 1, zero-extend if 0) and pairs are added, giving P+k+1 bits. No overflow is possible.
  - Layer k has INPUTS_AMOUNT>>(k+1) adders; pair j sums elements 2j and 2j+1.
- Output width rule:
  - OUT_W >= FW: sign- or zero-extend the FW-bit result per the beat's flag.
  - OUT_W < FW: take the low OUT_W bits (wrap, no saturation).
- Handshake, per stage s with register valid v[s]:
  - ready[s] = !v[s] | ready[s+1]; ready[S] = out_ready_i.
  - in_ready_o = ready[0].
  - Stage s loads when ready[s] is 1; it loads a valid beat if the upstream valid is 1, otherwise it clears v[s].
  - Data and signed-flag registers update only on a valid load; they may hold stale contents when v=0.
  - out_valid_o = v[S-1].
  - in_ready_o is combinational from out_ready_i (no skid buffer).
- Latency and throughput:
  - With no stall, a beat accepted in cycle t appears on out_o in cycle t+S.
  - Throughput is 1 beat/cycle.
  - Internal bubbles are collapsed when downstream stalls.
- S==0 case:
  - Pure combinational path: out_valid_o=in_valid_i, in_ready_o=out_ready_i, out_o is the combinational sum.
- Stall:
  - While out_valid_o=1 and out_ready_i=0, out_o and out_signed_o hold stable.
  - Beats are never dropped or duplicated.
- Reset (rst_ni=0, asynchronous):
  - All v[s]=0, data registers=0.
  - Hence out_valid_o=0, out_o=0, out_signed_o=0, in_ready_o=1 (when S>0).
- Reset mid-operation: all in-flight beats are lost. The first beat accepted after reset release produces the first output.
- clear_i:
  - Takes priority over loads in the same cycle: all v[s]<=0 at the next edge, data unchanged.
  - in_ready_o is forced to 0 while clear_i=1, so no beat is accepted that cycle.
- INPUTS_AMOUNT==1: out_o = extended inputs_i[0]; S=0.

Test Plan:
- INPUTS_AMOUNT=8, P=8, STRIDE=1, OUT_W=32, signed_i=1, all inputs 8'hFF (-1), out_ready_i=1 -> out_o=32'hFFFFFFF8 exactly 3 cycles after acceptance, out_signed_o=1.
- Same vector with signed_i=0 -> out_o=32'h000007F8 (2040) after 3 cycles; alternate signed_i 1/0 on back-to-back beats -> outputs alternate -8/2040 every cycle, no bubbles.
- STRIDE=2 with INPUTS_AMOUNT=8 (S=2): inputs 1..8 unsigned -> out_o=36 two cycles after acceptance. Hold out_ready_i=0 for 5 cycles with continuous in_valid_i -> exactly 2 beats buffered, in_ready_o=0 afterwards, out_o stable at 36. Release -> remaining beats emerge in order.
- OUT_W=10, P=8, INPUTS_AMOUNT=8, unsigned, all 8'hFF -> FW=11, out_o = 2040 mod 1024 = 10'h3F8.
- Assert rst_ni=0 asynchronously mid-clock with 3 beats in flight -> out_valid_o=0 and out_o=0 immediately. After release, only newly accepted beats appear; a one-cycle clear_i with 2 beats in flight -> zero outputs for those beats, in_ready_o=0 during clear.
- STRIDE=0 and INPUTS_AMOUNT=1 configurations: inputs_i[0]=8'h80, signed -> out_o=32'hFFFFFF80 in the same cycle; in_ready_o follows out_ready_i combinationally.
